triangle_raster: RTL and testbench
==================================

# triangle_raster

Sequential rasterizer sitting directly upstream of the point-in-triangle checker. On `start` it latches three vertices, computes their clamped bounding box and walks every pixel in it in raster order. For each pixel it drives the checker's `px`/`py`, waits the checker's fixed latency and samples `check`. Every pixel reported inside is emitted on a valid/ready write port toward the frame buffer.

## Interface
- `SCREEN_W`, default 640: horizontal resolution; x is clamped to `SCREEN_W-1`.
- `SCREEN_H`, default 480: vertical resolution; y is clamped to `SCREEN_H-1`.
- `CHECK_LATENCY`, default 2: clock cycles from `px`/`py` being stable to `check` being valid; range 0..15.

- `CLOCK_50`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `ax, ay, bx, by, cx, cy`  in  11 each  vertex coordinates, unsigned; sampled on the accepted `start`.
- `px, py`  out  11 each  pixel under test, registered; drives the checker.
- `check`  in  1  checker result for the current `px`/`py`; 1 means inside.
- `wr_valid`  out  1  inside-pixel write request.
- `wr_ready`  in  1  frame buffer accepts the write.
- `wr_x, wr_y`  out  11 each  write coordinates; stable while `wr_valid` is high.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE.
- `done`  out  1  one-cycle pulse at the end of the scan.
- `pix_count`  out  20  number of inside pixels written in the last scan.

## Operation
- Reset values: state IDLE; `px`, `py`, `wr_x`, `wr_y`, `pix_count` = 0; `wr_valid`, `busy`, `done` = 0.
- **IDLE**:
  - `start`=1 latches all six vertices, clears `pix_count` and goes to BBOX.
  - `start` in any other state is ignored.
- **BBOX** (1 cycle):
  - `xmin`/`xmax` = min/max of ax, bx, cx. `ymin`/`ymax` = min/max of ay, by, cy.
  - Each bound is then clamped to `SCREEN_W-1` or `SCREEN_H-1`.
  - Loads `px`=`xmin`, `py`=`ymin`, loads the wait counter and goes to PROBE.
- **PROBE**:
  - Holds `px`/`py` for `CHECK_LATENCY`+1 cycles, counting down.
  - On the last cycle it samples `check`. If 1, it loads `wr_x`/`wr_y` from `px`/`py`, sets `wr_valid` and goes to WRITE. If 0, it goes to ADVANCE.
- **WRITE**:
  - Holds `wr_valid`, `wr_x` and `wr_y` until the cycle where `wr_valid`&&`wr_ready` (the transfer).
  - On the transfer: `wr_valid` goes to 0, `pix_count` increments, and the state goes to ADVANCE.
  - `px`/`py` stay unchanged throughout.
- **ADVANCE** (1 cycle):
  - If `px`<`xmax`: `px`+1.
  - Else if `py`<`ymax`: `px`=`xmin`, `py`+1.
  - Else go to DONE.
  - On a move, the wait counter reloads and the state returns to PROBE.
- **DONE** (1 cycle): `done`=1, `busy`=0 in the same cycle; next state IDLE. `pix_count` holds until the next accepted `start`.
- Arithmetic: all coordinates unsigned 11-bit. Comparisons are unsigned. Increments never exceed the clamped max, so there is no wrap.
- Degenerate box (all vertices equal, or collinear): scanned normally. The minimum scan is 1 pixel. The inside decision belongs entirely to the checker.
- `reset` asserted in any state, including mid-WRITE with `wr_valid` high, returns to reset values on the next edge. The pending write is dropped.

## Timing
- From `start` accepted to the first `px`/`py` valid: 2 cycles (IDLE→BBOX→PROBE).
- Cycles per pixel:
  - Outside pixel: `CHECK_LATENCY`+2 (PROBE + ADVANCE).
  - Inside pixel with `wr_ready` held high: `CHECK_LATENCY`+3.
  - Each cycle of `wr_ready` low adds one cycle.
- `wr_valid` never deasserts without a transfer. `wr_x`/`wr_y` do not change while `wr_valid` is high.
- `done` is asserted exactly once per accepted `start`, in the cycle after the ADVANCE that finds (`xmax`,`ymax`).
- `busy` is high in BBOX, PROBE, WRITE and ADVANCE; it is low in IDLE and DONE.

## Test plan
- Bounding box: vertices (5,2), (1,9), (7,4) with the checker stub tied `check`=0. Required: the `px`/`py` sequence is (1,2)…(7,2), (1,3)…(7,9), 56 probes, `pix_count`=0, one `done` pulse.
- Inside writes with real triangle-area checker model (`CHECK_LATENCY`=2), `wr_ready`=1: right triangle (0,0), (3,0), (0,3). Required writes match a reference model point for point, `pix_count` equals the model count, and the total cycle count matches the Timing formula.
- Backpressure: `check` forced 1, single-pixel triangle (4,4)×3, `wr_ready` low for 5 cycles. Required: `wr_valid` high for 6 cycles, `wr_x`,`wr_y`=(4,4) stable, `pix_count`=1.
- Clamp: vertices (700,10), (10,10), (10,500) with SCREEN 640×480. Required: `xmax`=639, `ymax`=479, and no `px`>639 or `py`>479 ever appears.
- Reset mid-write and start while busy:
  - `reset` pulsed while `wr_valid`=1: next cycle all outputs are at reset values and state is IDLE.
  - `start` pulsed during PROBE: ignored, and the vertices are unchanged.
- Latency parameter sweep: with `CHECK_LATENCY` at 0, 2 and 7, `check` is sampled only on the last PROBE cycle. Verify by a stub whose output is valid exactly `CHECK_LATENCY` cycles after `px` changes and is garbage before that.

Source files
------------

// File: rtl/triangle_raster.sv
// triangle_raster: latches three vertices, derives their screen-clamped
// bounding box and walks every pixel in it in raster order. Each pixel is
// held on px/py long enough for the downstream point-in-triangle checker to
// settle; pixels reported inside are sent out on a valid/ready write port.
module triangle_raster #(
   parameter int SCREEN_W      = 640,
   parameter int SCREEN_H      = 480,
   parameter int CHECK_LATENCY = 2
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   input  logic [10:0] ax,
   input  logic [10:0] ay,
   input  logic [10:0] bx,
   input  logic [10:0] by,
   input  logic [10:0] cx,
   input  logic [10:0] cy,
   output logic [10:0] px,
   output logic [10:0] py,
   input  logic        check,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [10:0] wr_x,
   output logic [10:0] wr_y,
   output logic        busy,
   output logic        done,
   output logic [19:0] pix_count
);

   localparam logic [10:0] X_LIM     = 11'(SCREEN_W - 1);
   localparam logic [10:0] Y_LIM     = 11'(SCREEN_H - 1);
   // PROBE lasts WAIT_INIT+1 cycles; check is sampled when the counter hits 0
   localparam logic [3:0]  WAIT_INIT = 4'(CHECK_LATENCY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BBOX,
      S_PROBE,
      S_WRITE,
      S_ADVANCE,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [10:0] vx_q [3];
   logic [10:0] vx_d [3];
   logic [10:0] vy_q [3];
   logic [10:0] vy_d [3];
   logic [10:0] xmin_q, xmin_d, xmax_q, xmax_d;
   logic [10:0] ymin_q, ymin_d, ymax_q, ymax_d;
   logic [10:0] px_q, px_d, py_q, py_d;
   logic [10:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d;
   logic        wr_valid_q, wr_valid_d;
   logic [19:0] pix_count_q, pix_count_d;
   logic [3:0]  wait_q, wait_d;

   function automatic logic [10:0] min3(input logic [10:0] a,
                                        input logic [10:0] b,
                                        input logic [10:0] c);
      logic [10:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [10:0] max3(input logic [10:0] a,
                                        input logic [10:0] b,
                                        input logic [10:0] c);
      logic [10:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   function automatic logic [10:0] clamp(input logic [10:0] v,
                                         input logic [10:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   // Scan sequencer: next state and next value of every register
   always_comb begin
      state_d     = state_q;
      xmin_d      = xmin_q;
      xmax_d      = xmax_q;
      ymin_d      = ymin_q;
      ymax_d      = ymax_q;
      px_d        = px_q;
      py_d        = py_q;
      wr_x_d      = wr_x_q;
      wr_y_d      = wr_y_q;
      wr_valid_d  = wr_valid_q;
      pix_count_d = pix_count_q;
      wait_d      = wait_q;
      for (int i = 0; i < 3; i++) begin
         vx_d[i] = vx_q[i];
         vy_d[i] = vy_q[i];
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               vx_d[0]     = ax;
               vy_d[0]     = ay;
               vx_d[1]     = bx;
               vy_d[1]     = by;
               vx_d[2]     = cx;
               vy_d[2]     = cy;
               pix_count_d = 20'd0;
               state_d     = S_BBOX;
            end
         end
         S_BBOX: begin
            xmin_d  = clamp(min3(vx_q[0], vx_q[1], vx_q[2]), X_LIM);
            xmax_d  = clamp(max3(vx_q[0], vx_q[1], vx_q[2]), X_LIM);
            ymin_d  = clamp(min3(vy_q[0], vy_q[1], vy_q[2]), Y_LIM);
            ymax_d  = clamp(max3(vy_q[0], vy_q[1], vy_q[2]), Y_LIM);
            px_d    = xmin_d;
            py_d    = ymin_d;
            wait_d  = WAIT_INIT;
            state_d = S_PROBE;
         end
         S_PROBE: begin
            if (wait_q == 4'd0) begin
               if (check) begin
                  wr_x_d     = px_q;
                  wr_y_d     = py_q;
                  wr_valid_d = 1'b1;
                  state_d    = S_WRITE;
               end else begin
                  state_d = S_ADVANCE;
               end
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         S_WRITE: begin
            // wr_valid is only released by an actual transfer
            if (wr_ready) begin
               wr_valid_d  = 1'b0;
               pix_count_d = pix_count_q + 20'd1;
               state_d     = S_ADVANCE;
            end
         end
         S_ADVANCE: begin
            if (px_q < xmax_q) begin
               px_d    = px_q + 11'd1;
               wait_d  = WAIT_INIT;
               state_d = S_PROBE;
            end else if (py_q < ymax_q) begin
               px_d    = xmin_q;
               py_d    = py_q + 11'd1;
               wait_d  = WAIT_INIT;
               state_d = S_PROBE;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= S_IDLE;
         xmin_q      <= '0;
         xmax_q      <= '0;
         ymin_q      <= '0;
         ymax_q      <= '0;
         px_q        <= '0;
         py_q        <= '0;
         wr_x_q      <= '0;
         wr_y_q      <= '0;
         wr_valid_q  <= 1'b0;
         pix_count_q <= '0;
         wait_q      <= '0;
         for (int i = 0; i < 3; i++) begin
            vx_q[i] <= '0;
            vy_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         xmin_q      <= xmin_d;
         xmax_q      <= xmax_d;
         ymin_q      <= ymin_d;
         ymax_q      <= ymax_d;
         px_q        <= px_d;
         py_q        <= py_d;
         wr_x_q      <= wr_x_d;
         wr_y_q      <= wr_y_d;
         wr_valid_q  <= wr_valid_d;
         pix_count_q <= pix_count_d;
         wait_q      <= wait_d;
         for (int i = 0; i < 3; i++) begin
            vx_q[i] <= vx_d[i];
            vy_q[i] <= vy_d[i];
         end
      end
   end

   assign px        = px_q;
   assign py        = py_q;
   assign wr_x      = wr_x_q;
   assign wr_y      = wr_y_q;
   assign wr_valid  = wr_valid_q;
   assign pix_count = pix_count_q;
   assign busy      = (state_q == S_BBOX)  || (state_q == S_PROBE) ||
                      (state_q == S_WRITE) || (state_q == S_ADVANCE);
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_triangle_raster.sv
// Bench for triangle_raster: three instances (CHECK_LATENCY 2, 0, 7) share
// start/vertices/wr_ready. Each has its own checker stub whose answer is only
// valid CHECK_LATENCY cycles after px/py move (random bit before that).
module tb_triangle_raster;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        start    = 1'b0;
   logic [10:0] ax = '0, ay = '0, bx = '0, by = '0, cx = '0, cy = '0;
   logic        wr_ready = 1'b1;

   logic [10:0] px_w   [3];
   logic [10:0] py_w   [3];
   logic [10:0] wr_x_w [3];
   logic [10:0] wr_y_w [3];
   logic [19:0] pc_w   [3];
   logic        check_w    [3];
   logic        wr_valid_w [3];
   logic        busy_w     [3];
   logic        done_w     [3];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int start_cyc = 0;
   int check_mode = 0;   // 0: always outside, 1: always inside, 2: triangle
   int tri_ax = 0, tri_ay = 0, tri_bx = 0, tri_by = 0, tri_cx = 0, tri_cy = 0;
   bit rand_ready_en = 1'b0;

   // per-instance observations of the current scan
   int probe_n  [3];
   int wr_n     [3];
   int done_cnt [3];
   int done_cyc [3];
   int stalls   [3];
   int viol     [3];
   int vcyc     [3];
   int probe_mem [3][2048];
   int wr_mem    [3][2048];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 0 : 7);
   endfunction

   function automatic int edge_fn(input int x0, input int y0, input int x1,
                                  input int y1, input int x, input int y);
      return (x1 - x0) * (y - y0) - (y1 - y0) * (x - x0);
   endfunction

   // Reference point-in-triangle (edges count as inside)
   function automatic bit ref_inside(input int mode, input int x, input int y,
                                     input int x0, input int y0, input int x1,
                                     input int y1, input int x2, input int y2);
      int d0, d1, d2;
      if (mode == 0) return 1'b0;
      if (mode == 1) return 1'b1;
      d0 = edge_fn(x0, y0, x1, y1, x, y);
      d1 = edge_fn(x1, y1, x2, y2, x, y);
      d2 = edge_fn(x2, y2, x0, y0, x, y);
      return (d0 >= 0 && d1 >= 0 && d2 >= 0) || (d0 <= 0 && d1 <= 0 && d2 <= 0);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_inst
      localparam int L = lat_of(gi);

      logic [10:0] lpx = '0, lpy = '0;
      int          age = 100;
      logic        garbage = 1'b0;
      logic        chg;
      logic        truth;
      int          eff_age;

      assign chg     = (px_w[gi] != lpx) || (py_w[gi] != lpy);
      assign eff_age = chg ? 0 : age;
      assign truth   = ref_inside(check_mode, int'(px_w[gi]), int'(py_w[gi]),
                                  tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy);
      assign check_w[gi] = (eff_age >= L) ? truth : garbage;

      // checker stub: tracks how long px/py have been stable
      always @(posedge clk) begin
         lpx <= px_w[gi];
         lpy <= py_w[gi];
         if (chg) age <= 1;
         else if (age < 100) age <= age + 1;
         garbage <= 1'($urandom_range(0, 1));
      end

      triangle_raster #(
         .SCREEN_W(640), .SCREEN_H(480), .CHECK_LATENCY(L)
      ) u_dut (
         .CLOCK_50(clk), .reset(reset), .start(start),
         .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
         .px(px_w[gi]), .py(py_w[gi]), .check(check_w[gi]),
         .wr_valid(wr_valid_w[gi]), .wr_ready(wr_ready),
         .wr_x(wr_x_w[gi]), .wr_y(wr_y_w[gi]),
         .busy(busy_w[gi]), .done(done_w[gi]), .pix_count(pc_w[gi])
      );

      logic        vprev = 1'b0, rdyprev = 1'b0, rstprev = 1'b1, bprev = 1'b0;
      logic [10:0] xprev = '0, yprev = '0;

      // observer: records probes, writes, done, stalls and protocol slips
      always @(negedge clk) begin
         if (px_w[gi] > 11'd639 || py_w[gi] > 11'd479) viol[gi] = viol[gi] + 1;
         if (vprev && !rdyprev && !rstprev &&
             (!wr_valid_w[gi] || wr_x_w[gi] != xprev || wr_y_w[gi] != yprev))
            viol[gi] = viol[gi] + 1;
         if (wr_valid_w[gi]) begin
            vcyc[gi] = vcyc[gi] + 1;
            if (wr_ready) begin
               if (wr_n[gi] < 2048)
                  wr_mem[gi][wr_n[gi]] = int'(wr_x_w[gi]) * 4096 + int'(wr_y_w[gi]);
               wr_n[gi] = wr_n[gi] + 1;
            end else begin
               stalls[gi] = stalls[gi] + 1;
            end
         end
         if (busy_w[gi] && bprev && probe_n[gi] < 2048) begin
            if (probe_n[gi] == 0 ||
                probe_mem[gi][probe_n[gi] - 1] != int'(px_w[gi]) * 4096 + int'(py_w[gi])) begin
               probe_mem[gi][probe_n[gi]] = int'(px_w[gi]) * 4096 + int'(py_w[gi]);
               probe_n[gi] = probe_n[gi] + 1;
            end
         end
         if (done_w[gi]) begin
            done_cnt[gi] = done_cnt[gi] + 1;
            done_cyc[gi] = cyc;
            if (busy_w[gi]) viol[gi] = viol[gi] + 1;
         end
         vprev   = wr_valid_w[gi];
         rdyprev = wr_ready;
         rstprev = reset;
         bprev   = busy_w[gi];
         xprev   = wr_x_w[gi];
         yprev   = wr_y_w[gi];
      end
   end

   // random write backpressure when enabled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready_en) wr_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic start_scan(input int mode, input int x0, input int y0,
                             input int x1, input int y1, input int x2, input int y2);
      check_mode = mode;
      tri_ax = x0; tri_ay = y0; tri_bx = x1; tri_by = y1; tri_cx = x2; tri_cy = y2;
      ax = 11'(x0); ay = 11'(y0); bx = 11'(x1); by = 11'(y1); cx = 11'(x2); cy = 11'(y2);
      for (int i = 0; i < 3; i++) begin
         probe_n[i] = 0; wr_n[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0;
         stalls[i] = 0; viol[i] = 0; vcyc[i] = 0;
      end
      @(posedge clk);
      #1;
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Compare every instance against a plain raster walk of the clamped box
   task automatic verify_scan(input string name);
      int xmn, xmx, ymn, ymx, k, w, pm, wm, lat, enc;
      xmn = tri_ax; if (tri_bx < xmn) xmn = tri_bx; if (tri_cx < xmn) xmn = tri_cx;
      xmx = tri_ax; if (tri_bx > xmx) xmx = tri_bx; if (tri_cx > xmx) xmx = tri_cx;
      ymn = tri_ay; if (tri_by < ymn) ymn = tri_by; if (tri_cy < ymn) ymn = tri_cy;
      ymx = tri_ay; if (tri_by > ymx) ymx = tri_by; if (tri_cy > ymx) ymx = tri_cy;
      if (xmn > 639) xmn = 639;
      if (xmx > 639) xmx = 639;
      if (ymn > 479) ymn = 479;
      if (ymx > 479) ymx = 479;
      for (int i = 0; i < 3; i++) begin
         k = 0; w = 0; pm = 0; wm = 0; lat = lat_of(i);
         for (int y = ymn; y <= ymx; y++) begin
            for (int x = xmn; x <= xmx; x++) begin
               enc = x * 4096 + y;
               if (k < probe_n[i] && k < 2048 && probe_mem[i][k] != enc) pm++;
               k++;
               if (ref_inside(check_mode, x, y, tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy)) begin
                  if (w < wr_n[i] && w < 2048 && wr_mem[i][w] != enc) wm++;
                  w++;
               end
            end
         end
         check_eq($sformatf("%s L%0d probe_count", name, lat), probe_n[i], k);
         check_eq($sformatf("%s L%0d probe_order_errs", name, lat), pm, 0);
         check_eq($sformatf("%s L%0d write_count", name, lat), wr_n[i], w);
         check_eq($sformatf("%s L%0d write_coord_errs", name, lat), wm, 0);
         check_eq($sformatf("%s L%0d pix_count", name, lat), 32'(pc_w[i]), w);
         check_eq($sformatf("%s L%0d done_pulses", name, lat), done_cnt[i], 1);
         check_eq($sformatf("%s L%0d cycles", name, lat), done_cyc[i] - start_cyc,
                  2 + k * (lat + 2) + w + stalls[i]);
         check_eq($sformatf("%s L%0d protocol_errs", name, lat), viol[i], 0);
         $display("scan %s L%0d: probes=%0d writes=%0d pix_count=%0d cycles=%0d",
                  name, lat, probe_n[i], wr_n[i], pc_w[i], done_cyc[i] - start_cyc);
      end
   endtask

   task automatic finish_scan(input string name);
      int n;
      n = 0;
      while (!(done_cnt[0] >= 1 && done_cnt[1] >= 1 && done_cnt[2] >= 1) && n < 20000) begin
         @(posedge clk);
         n++;
      end
      check_eq({name, " done_timeout"}, 32'(n < 20000), 1);
      repeat (3) @(posedge clk);
      #1;
      verify_scan(name);
   endtask

   task automatic wait_valid0(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!wr_valid_w[0] && n < 200);
      check_eq({name, " wr_valid_timeout"}, 32'(n < 200), 1);
   endtask

   task automatic check_reset_outputs(input string name);
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("%s[%0d] px", name, i), 32'(px_w[i]), 0);
         check_eq($sformatf("%s[%0d] py", name, i), 32'(py_w[i]), 0);
         check_eq($sformatf("%s[%0d] wr_x", name, i), 32'(wr_x_w[i]), 0);
         check_eq($sformatf("%s[%0d] wr_y", name, i), 32'(wr_y_w[i]), 0);
         check_eq($sformatf("%s[%0d] pix_count", name, i), 32'(pc_w[i]), 0);
         check_eq($sformatf("%s[%0d] wr_valid", name, i), 32'(wr_valid_w[i]), 0);
         check_eq($sformatf("%s[%0d] busy", name, i), 32'(busy_w[i]), 0);
         check_eq($sformatf("%s[%0d] done", name, i), 32'(done_w[i]), 0);
      end
      $display("reset check %s done", name);
   endtask

   initial begin
      int rx, ry;
      for (int i = 0; i < 3; i++) begin
         probe_n[i] = 0; wr_n[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0;
         stalls[i] = 0; viol[i] = 0; vcyc[i] = 0;
      end

      // reset state
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("power_on");

      // bounding-box walk with checker tied low
      start_scan(0, 5, 2, 1, 9, 7, 4);
      finish_scan("bbox");
      check_eq("bbox probes L2", probe_n[0], 56);

      // right triangle with the real area checker
      start_scan(2, 0, 0, 3, 0, 0, 3);
      finish_scan("right_tri");
      check_eq("right_tri pix_count L2", 32'(pc_w[0]), 10);

      // backpressure on a single inside pixel
      wr_ready = 1'b0;
      start_scan(1, 4, 4, 4, 4, 4, 4);
      wait_valid0("backpressure");
      repeat (5) @(posedge clk);
      #1 wr_ready = 1'b1;
      finish_scan("backpressure");
      check_eq("backpressure valid_cycles L2", vcyc[0], 6);
      check_eq("backpressure wr_x", 32'(wr_x_w[0]), 4);
      check_eq("backpressure wr_y", 32'(wr_y_w[0]), 4);

      // clamp: box pushed past the right/bottom edges
      start_scan(2, 700, 470, 630, 470, 630, 500);
      finish_scan("clamp");
      check_eq("clamp last_probe L2", probe_mem[0][(probe_n[0] > 0) ? probe_n[0] - 1 : 0],
               639 * 4096 + 479);
      start_scan(2, 700, 600, 700, 600, 700, 600);
      finish_scan("clamp_point");

      // start during PROBE with different vertices on the inputs is ignored
      start_scan(2, 2, 1, 9, 3, 4, 8);
      @(posedge clk);
      @(posedge clk);
      #1;
      ax = 11'($urandom_range(20, 600)); ay = 11'($urandom_range(20, 400));
      bx = 11'($urandom_range(20, 600)); by = 11'($urandom_range(20, 400));
      cx = 11'($urandom_range(20, 600)); cy = 11'($urandom_range(20, 400));
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      finish_scan("start_in_probe");

      // random triangles, some straddling the screen edge, random backpressure
      rand_ready_en = 1'b1;
      for (int r = 0; r < 5; r++) begin
         rx = ($urandom_range(0, 1) == 1) ? 628 : 0;
         ry = ($urandom_range(0, 1) == 1) ? 468 : 0;
         start_scan(2, rx + $urandom_range(0, 14), ry + $urandom_range(0, 14),
                       rx + $urandom_range(0, 14), ry + $urandom_range(0, 14),
                       rx + $urandom_range(0, 14), ry + $urandom_range(0, 14));
         finish_scan($sformatf("random%0d", r));
      end
      rand_ready_en = 1'b0;
      @(posedge clk);
      #1 wr_ready = 1'b0;

      // reset while a write is pending
      start_scan(1, 2, 2, 4, 2, 2, 4);
      wait_valid0("reset_mid_write");
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_write");
      wr_ready = 1'b1;
      repeat (2) @(posedge clk);

      // a fresh scan after reset starts from IDLE
      start_scan(2, 1, 1, 6, 2, 3, 5);
      finish_scan("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
